iecdrv_sd_arbiter: RTL and testbench



---
 rtl/iecdrv_sd_arbiter_pkg.sv | 21 ++
 rtl/iecdrv_sd_arbiter_if.sv | 36 +++
 rtl/iecdrv_sd_arbiter_rr_pick.sv | 28 ++
 rtl/iecdrv_sd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_iecdrv_sd_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iecdrv_sd_arbiter_pkg.sv
// Shared types for the multi-drive SD sector arbiter: FSM states, drive index
// type and the round-robin pointer advance helper.
package iecdrv_pkg;

    localparam int MAX_DRIVES = 4;

    typedef logic [1:0] drv_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        GAP
    } arb_state_t;

    // Next round-robin start point after drive g has been served.
    function automatic drv_idx_t rr_next(input drv_idx_t g, input int ndr);
        rr_next = (int'(g) >= ndr - 1) ? drv_idx_t'(0) : drv_idx_t'(g + 2'd1);
    endfunction

endpackage

// File: rtl/iecdrv_sd_arbiter_if.sv
// Per-drive request ports plus the single host sector-I/O channel.
// Modport master is the arbiter's view, slave is the drives/host side.
interface iecdrv_sd_arbiter_if
    import iecdrv_pkg::*;
#(
    parameter int NDR = 2
);
    logic [NDR-1:0][31:0] drv_lba;
    logic [NDR-1:0][5:0]  drv_blk_cnt;
    logic [NDR-1:0]       drv_rd;
    logic [NDR-1:0]       drv_wr;
    logic [NDR-1:0]       drv_ack;
    logic [NDR-1:0][7:0]  drv_buff_din;

    logic [31:0]          host_lba;
    logic [5:0]           host_blk_cnt;
    logic                 host_rd;
    logic                 host_wr;
    drv_idx_t             host_drv;
    logic                 host_ack;
    logic [7:0]           host_buff_din;
    logic                 busy;

    modport master (
        input  drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, host_ack,
        output drv_ack, host_lba, host_blk_cnt, host_rd, host_wr, host_drv,
               host_buff_din, busy
    );

    modport slave (
        output drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, host_ack,
        input  drv_ack, host_lba, host_blk_cnt, host_rd, host_wr, host_drv,
               host_buff_din, busy
    );

endinterface

// File: rtl/iecdrv_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending drive at or after i_rr,
// wrapping modulo NDR.
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [NDR-1:0] i_pending,
    input  drv_idx_t       i_rr,
    output drv_idx_t       o_idx,
    output logic           o_valid
);

    // Walk distances from the farthest to the nearest so the nearest hit wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NDR - 1; k >= 0; k--) begin
            for (int i = 0; i < NDR; i++) begin
                if (i_pending[i] && (((int'(i_rr) + k) % NDR) == i)) begin
                    o_idx   = drv_idx_t'(i);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter serialising per-drive SD sector requests onto one host
// channel. Optional REQ-stage ack timeout: define IECDRV_SD_ARB_TIMEOUT_EN.
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int NDR  = 2,
    parameter int TO_W = 20
) (
    input  logic                clk_sys,
    input  logic                reset,
    iecdrv_sd_arbiter_if.master bus
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    ,
    output logic                timeout
`endif
);

    if (NDR < 1 || NDR > MAX_DRIVES || TO_W < 2) begin : g_param_check
        $error("iecdrv_sd_arbiter: NDR must be 1..4 and TO_W at least 2");
    end

    arb_state_t     r_state, w_next_state;
    drv_idx_t       r_rr, w_rr_nxt;
    drv_idx_t       r_host_drv, w_host_drv_nxt;
    logic [31:0]    r_host_lba, w_host_lba_nxt;
    logic [5:0]     r_host_blk_cnt, w_host_blk_cnt_nxt;
    logic           r_host_rd, w_host_rd_nxt;
    logic           r_host_wr, w_host_wr_nxt;
    logic           r_busy, w_busy_nxt;

    logic [NDR-1:0] w_pending;
    drv_idx_t       w_pick_idx;
    logic           w_pick_valid;
    logic [31:0]    w_sel_lba;
    logic [5:0]     w_sel_blk;
    logic           w_sel_rd, w_sel_wr;
    logic           w_cur_pending;
    logic           w_timeout_hit;

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            r_timeout, w_timeout_nxt;

    assign w_timeout_hit = &r_to_cnt;
    assign w_to_cnt_nxt  = (r_state == REQ) ? r_to_cnt + 1'b1 : '0;
    assign w_timeout_nxt = (r_state == REQ) && !bus.host_ack && w_cur_pending && w_timeout_hit;
    assign timeout       = r_timeout;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    assign w_pending = bus.drv_rd | bus.drv_wr;

    iecdrv_rr_pick #(.NDR(NDR)) u_pick (
        .i_pending (w_pending),
        .i_rr      (r_rr),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    // Request mux follows the picker; data mux follows the latched grant.
    always_comb begin
        // NOTE: every variable gets a default before the loop, otherwise an
        // unmatched index would leave it holding its old value (a latch).
        w_sel_lba         = '0;
        w_sel_blk         = '0;
        w_sel_rd          = 1'b0;
        w_sel_wr          = 1'b0;
        w_cur_pending     = 1'b0;
        bus.host_buff_din = '0;
        for (int i = 0; i < NDR; i++) begin
            if (w_pick_idx == drv_idx_t'(i)) begin
                w_sel_lba = bus.drv_lba[i];
                w_sel_blk = bus.drv_blk_cnt[i];
                w_sel_rd  = bus.drv_rd[i];
                w_sel_wr  = bus.drv_wr[i];
            end
            if (r_host_drv == drv_idx_t'(i)) begin
                w_cur_pending     = w_pending[i];
                bus.host_buff_din = bus.drv_buff_din[i];
            end
        end
    end

    always_comb begin
        bus.drv_ack = '0;
        for (int i = 0; i < NDR; i++) begin
            bus.drv_ack[i] = bus.host_ack && (r_state == REQ || r_state == XFER)
                             && (r_host_drv == drv_idx_t'(i));
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_pick_valid) w_next_state = REQ;
            REQ: begin
                if (bus.host_ack)        w_next_state = XFER;
                else if (!w_cur_pending) w_next_state = IDLE;
                else if (w_timeout_hit)  w_next_state = GAP;
            end
            XFER: if (!bus.host_ack) w_next_state = GAP;
            GAP:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_rr_nxt           = r_rr;
        w_host_drv_nxt     = r_host_drv;
        w_host_lba_nxt     = r_host_lba;
        w_host_blk_cnt_nxt = r_host_blk_cnt;
        w_host_rd_nxt      = r_host_rd;
        w_host_wr_nxt      = r_host_wr;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_host_drv_nxt     = w_pick_idx;
                    w_host_lba_nxt     = w_sel_lba;
                    w_host_blk_cnt_nxt = w_sel_blk;
                    w_host_wr_nxt      = w_sel_wr;
                    w_host_rd_nxt      = w_sel_rd & ~w_sel_wr;
                end
            end
            REQ: begin
                // A withdrawn request does not advance the pointer; a timeout does.
                if (bus.host_ack || !w_cur_pending) begin
                    w_host_rd_nxt = 1'b0;
                    w_host_wr_nxt = 1'b0;
                end else if (w_timeout_hit) begin
                    w_host_rd_nxt = 1'b0;
                    w_host_wr_nxt = 1'b0;
                    w_rr_nxt      = rr_next(r_host_drv, NDR);
                end
            end
            XFER: if (!bus.host_ack) w_rr_nxt = rr_next(r_host_drv, NDR);
            default: ;
        endcase
        w_busy_nxt = (w_next_state != IDLE);
    end

    // NOTE: all state uses non-blocking assignments and the asynchronous
    // reset, so a reset mid-transfer clears every registered output at once.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rr           <= '0;
            r_host_drv     <= '0;
            r_host_lba     <= '0;
            r_host_blk_cnt <= '0;
            r_host_rd      <= 1'b0;
            r_host_wr      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_rr           <= w_rr_nxt;
            r_host_drv     <= w_host_drv_nxt;
            r_host_lba     <= w_host_lba_nxt;
            r_host_blk_cnt <= w_host_blk_cnt_nxt;
            r_host_rd      <= w_host_rd_nxt;
            r_host_wr      <= w_host_wr_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign bus.host_drv     = r_host_drv;
    assign bus.host_lba     = r_host_lba;
    assign bus.host_blk_cnt = r_host_blk_cnt;
    assign bus.host_rd      = r_host_rd;
    assign bus.host_wr      = r_host_wr;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Self-checking bench for iecdrv_sd_arbiter with four drives: vector table,
// directed corner sequences and a randomized run against a transaction model.
module tb_iecdrv_sd_arbiter;
    import iecdrv_pkg::*;

    localparam int NDR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iecdrv_sd_arbiter_if #(.NDR(NDR)) bus ();
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    logic tmo;
`endif

    iecdrv_sd_arbiter #(.NDR(NDR), .TO_W(4)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
        ,
        .timeout (tmo)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       valid;
        logic [1:0] drv;
        logic       hrd;
        logic       hwr;
    } vec_t;

    vec_t       vecs[8];
    logic [1:0] exp_order[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.drv_rd       = '0;
        bus.drv_wr       = '0;
        bus.drv_lba      = '0;
        bus.drv_blk_cnt  = '0;
        bus.drv_buff_din = '0;
        bus.host_ack     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!(bus.host_rd || bus.host_wr) && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(bus.host_rd | bus.host_wr), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   64'(bus.host_rd), 64'd0);
        check({tag, "_wr"},   64'(bus.host_wr), 64'd0);
        check({tag, "_drv"},  64'(bus.host_drv), 64'd0);
        check({tag, "_lba"},  64'(bus.host_lba), 64'd0);
        check({tag, "_blk"},  64'(bus.host_blk_cnt), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_ack"},  64'(bus.drv_ack), 64'd0);
    endtask

    // Transaction-level model state for the random run.
    bit          m_act[4];
    bit          m_w[4];
    logic [31:0] m_lba[4];
    logic [7:0]  m_din[4];
    int          m_rr;
    int          m_g;

    task automatic apply_drives();
        for (int i = 0; i < 4; i++) begin
            bus.drv_rd[i]       = m_act[i] & ~m_w[i];
            bus.drv_wr[i]       = m_act[i] & m_w[i];
            bus.drv_lba[i]      = m_lba[i];
            bus.drv_buff_din[i] = m_din[i];
        end
    endtask

    initial begin
        vecs[0] = '{4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[2] = '{4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1};
        vecs[3] = '{4'b0110, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[4] = '{4'b1100, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 4'b1010, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[7] = '{4'b0000, 4'b1010, 1'b1, 2'd1, 1'b0, 1'b1};
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state
        clear_inputs();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Vector table: each request is withdrawn in REQ, so rr stays 0.
        for (int v = 0; v < 8; v++) begin
            bus.drv_lba     = {32'h103, 32'h102, 32'h101, 32'h100};
            bus.drv_blk_cnt = {6'd3, 6'd2, 6'd1, 6'd0};
            bus.drv_rd      = vecs[v].rd;
            bus.drv_wr      = vecs[v].wr;
            tick();
            check($sformatf("vec%0d_busy", v), 64'(bus.busy), 64'(vecs[v].valid));
            check($sformatf("vec%0d_rd", v), 64'(bus.host_rd), 64'(vecs[v].hrd));
            check($sformatf("vec%0d_wr", v), 64'(bus.host_wr), 64'(vecs[v].hwr));
            if (vecs[v].valid) begin
                check($sformatf("vec%0d_drv", v), 64'(bus.host_drv), 64'(vecs[v].drv));
                check($sformatf("vec%0d_lba", v), 64'(bus.host_lba), 64'(32'h100 + 32'(vecs[v].drv)));
                check($sformatf("vec%0d_blk", v), 64'(bus.host_blk_cnt), 64'(vecs[v].drv));
            end
            bus.drv_rd = '0;
            bus.drv_wr = '0;
            tick();
            check($sformatf("vec%0d_idle", v), 64'(bus.busy), 64'd0);
        end

        // Spurious ack in IDLE, then a single read on drive 1
        bus.host_ack = 1'b1;
        #1;
        check("spurious_drv_ack", 64'(bus.drv_ack), 64'd0);
        tick();
        check("spurious_busy", 64'(bus.busy), 64'd0);
        bus.host_ack    = 1'b0;
        bus.drv_lba     = '0;
        bus.drv_lba[1]  = 32'h12;
        bus.drv_blk_cnt = '0;
        bus.drv_rd      = 4'b0010;
        #1;
        check("rd_before_edge", 64'(bus.host_rd), 64'd0);
        tick();
        check("rd_rd", 64'(bus.host_rd), 64'd1);
        check("rd_drv", 64'(bus.host_drv), 64'd1);
        check("rd_lba", 64'(bus.host_lba), 64'h12);
        check("rd_blk", 64'(bus.host_blk_cnt), 64'd0);
        bus.host_ack = 1'b1;
        #1;
        check("rd_drv_ack", 64'(bus.drv_ack), 64'b0010);
        tick();
        check("rd_rd_clr", 64'(bus.host_rd), 64'd0);
        check("rd_xfer_busy", 64'(bus.busy), 64'd1);
        bus.drv_rd   = '0;
        bus.host_ack = 1'b0;
        #1;
        check("rd_ack_fall", 64'(bus.drv_ack), 64'd0);
        tick();
        check("rd_gap_busy", 64'(bus.busy), 64'd1);
        tick();
        check("rd_idle_busy", 64'(bus.busy), 64'd0);

        // Write mux on drive 2
        do_reset();
        bus.drv_buff_din = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.drv_wr       = 4'b0100;
        tick();
        check("wr_wr", 64'(bus.host_wr), 64'd1);
        check("wr_rd", 64'(bus.host_rd), 64'd0);
        check("wr_drv", 64'(bus.host_drv), 64'd2);
        bus.host_ack = 1'b1;
        tick();
        check("wr_wr_clr", 64'(bus.host_wr), 64'd0);
        check("wr_buff", 64'(bus.host_buff_din), 64'hA5);
        check("wr_drv_ack", 64'(bus.drv_ack), 64'b0100);
        bus.drv_buff_din[2] = 8'h3C;
        #1;
        check("wr_buff_follow", 64'(bus.host_buff_din), 64'h3C);
        bus.drv_wr   = '0;
        bus.host_ack = 1'b0;
        tick();
        tick();
        check("wr_idle", 64'(bus.busy), 64'd0);

        // Withdraw on drive 3 (rr is now 3 after drive 2 was served)
        bus.drv_rd = 4'b1000;
        tick();
        check("wd_rd", 64'(bus.host_rd), 64'd1);
        check("wd_drv", 64'(bus.host_drv), 64'd3);
        bus.drv_rd = '0;
        #1;
        check("wd_no_ack0", 64'(bus.drv_ack), 64'd0);
        tick();
        check("wd_rd_clr", 64'(bus.host_rd), 64'd0);
        check("wd_idle", 64'(bus.busy), 64'd0);
        check("wd_no_ack1", 64'(bus.drv_ack), 64'd0);

        // Round robin, all four drives, drive 0 re-raises during drive 1
        do_reset();
        bus.drv_rd = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_req($sformatf("rr%0d_req", t));
            check($sformatf("rr%0d_drv", t), 64'(bus.host_drv), 64'(exp_order[t]));
            bus.host_ack = 1'b1;
            #1;
            check($sformatf("rr%0d_ack", t), 64'(bus.drv_ack), 64'd1 << exp_order[t]);
            bus.drv_rd[exp_order[t]] = 1'b0;
            if (exp_order[t] == 2'd1) bus.drv_rd[0] = 1'b1;
            tick();
            tick();
            bus.host_ack = 1'b0;
            tick();
        end

        // Asynchronous reset in the middle of a transfer
        do_reset();
        bus.drv_lba[2] = 32'hDEAD_BEEF;
        bus.drv_rd     = 4'b0100;
        tick();
        bus.host_ack = 1'b1;
        tick();
        check("arst_pre_busy", 64'(bus.busy), 64'd1);
        check("arst_pre_lba", 64'(bus.host_lba), 64'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        bus.host_ack = 1'b0;
        bus.drv_rd   = 4'b0001;
        #2;
        rst = 1'b0;
        tick();
        check("arst_after_rd", 64'(bus.host_rd), 64'd1);
        check("arst_after_drv", 64'(bus.host_drv), 64'd0);
        bus.drv_rd = '0;
        tick();

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
        // Stalled host: TO_W=4, drive 0 stays pending, drive 1 waits behind it
        do_reset();
        bus.drv_rd = 4'b0011;
        tick();
        check("to_drv0", 64'(bus.host_drv), 64'd0);
        begin
            int n = 0;
            while (!tmo && n < 40) begin
                tick();
                n++;
            end
            check("to_latency", 64'(n), 64'd16);
        end
        check("to_rd_clr", 64'(bus.host_rd), 64'd0);
        check("to_no_ack", 64'(bus.drv_ack), 64'd0);
        tick();
        check("to_pulse_len", 64'(tmo), 64'd0);
        tick();
        check("to_next_rd", 64'(bus.host_rd), 64'd1);
        check("to_next_drv", 64'(bus.host_drv), 64'd1);
        bus.drv_rd = '0;
        tick();
`endif

        // Randomized traffic against the transaction model
        do_reset();
        begin
            bit prev_req = 1'b0;
            bit in_xfer  = 1'b0;
            int wait_cnt = 0;
            int ack_cnt  = 0;
            int grants   = 0;
            m_rr = 0;
            m_g  = 0;
            for (int i = 0; i < 4; i++) begin
                m_act[i] = 1'b0;
                m_w[i]   = 1'b0;
                m_lba[i] = '0;
                m_din[i] = '0;
            end
            for (int cyc = 0; cyc < 2000; cyc++) begin
                bit cur_req;
                tick();
                cur_req = bus.host_rd | bus.host_wr;
                if (cur_req && !prev_req) begin
                    int e = -1;
                    for (int k = 3; k >= 0; k--) begin
                        if (m_act[(m_rr + k) % 4]) e = (m_rr + k) % 4;
                    end
                    check("rand_grant_valid", 64'(e >= 0), 64'd1);
                    if (e < 0) e = 0;
                    check("rand_grant_drv", 64'(bus.host_drv), 64'(e));
                    check("rand_grant_lba", 64'(bus.host_lba), 64'(m_lba[e]));
                    check("rand_grant_wr", 64'(bus.host_wr), 64'(m_w[e]));
                    check("rand_grant_rd", 64'(bus.host_rd), 64'(!m_w[e]));
                    m_g      = e;
                    wait_cnt = int'($urandom_range(0, 3));
                    grants++;
                end
                prev_req = cur_req;

                if (in_xfer) begin
                    if (ack_cnt == 0) begin
                        bus.host_ack = 1'b0;
                        in_xfer      = 1'b0;
                        m_rr         = (m_g + 1) % 4;
                    end else begin
                        ack_cnt--;
                    end
                end else if (cur_req) begin
                    if (wait_cnt == 0) begin
                        bus.host_ack = 1'b1;
                        in_xfer      = 1'b1;
                        ack_cnt      = int'($urandom_range(1, 4));
                    end else begin
                        wait_cnt--;
                    end
                end

                for (int i = 0; i < 4; i++) begin
                    if (!m_act[i] && $urandom_range(0, 3) == 0) begin
                        m_act[i] = 1'b1;
                        m_w[i]   = 1'($urandom_range(0, 1));
                        m_lba[i] = $urandom;
                        m_din[i] = 8'($urandom);
                    end
                end
                apply_drives();
                #1;
                check("rand_drv_ack", 64'(bus.drv_ack),
                      bus.host_ack ? (64'd1 << m_g) : 64'd0);
                if (bus.host_ack) begin
                    check("rand_buff", 64'(bus.host_buff_din), 64'(m_din[m_g]));
                    m_act[m_g] = 1'b0;
                    apply_drives();
                end
            end
            check("rand_progress", 64'(grants > 50), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
